// File: rtl/step_request_arbiter.sv
`default_nettype none
// ============================================================================
// step_request_arbiter : round-robin drain of queued one-shot up/down steps
//                        onto one shared wrap-around counter.  Revision 1.0
// ============================================================================
module step_request_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int WIDTH    = 3,
   parameter int PEND_W   = 2,
   parameter int STEP_GAP = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_in,
   input  logic [NUM_REQ-1:0]         dir_in,
   input  logic                       enable,
   output logic [WIDTH-1:0]           count,
   output logic                       step_pulse,
   output logic                       step_dir,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic [NUM_REQ-1:0]         pend_ovf,
   output logic                       busy
);

   localparam int                c_id_w     = $clog2(NUM_REQ);
   localparam int                c_gap_w    = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
   localparam logic [PEND_W-1:0] c_pend_max = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_STEP  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_req_q;
   logic [NUM_REQ-1:0]   r_sdir;
   logic [NUM_REQ-1:0]   r_ovf;
   logic [PEND_W-1:0]    r_pend [NUM_REQ];
   logic [c_id_w-1:0]    r_rr_ptr;
   logic [c_id_w-1:0]    r_grant_id;
   logic                 r_step_dir;
   logic                 r_pulse;
   logic [WIDTH-1:0]     r_count;
   logic [c_gap_w-1:0]   r_gap;

   logic [NUM_REQ-1:0]   w_edge;
   logic [NUM_REQ-1:0]   w_sdir_next;
   logic [NUM_REQ-1:0]   w_ovf_set;
   logic [PEND_W-1:0]    w_pend_next [NUM_REQ];
   logic [NUM_REQ-1:0]   w_pend_nz;
   logic [NUM_REQ-1:0]   w_next_nz;
   logic [c_id_w-1:0]    w_rr_after;
   logic [c_id_w:0]      w_pick_now;
   logic [c_id_w:0]      w_pick_step;

   // Returns {found, index} of the first set bit at or above ptr, wrapping.
   function automatic logic [c_id_w:0] pick(input logic [NUM_REQ-1:0] nz,
                                             input logic [c_id_w-1:0]  ptr);
      logic [c_id_w:0] res;
      int              j;
      res = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (nz[j]) res = {1'b1, c_id_w'(j)};
      end
      return res;
   endfunction

   // Step decrement is applied before the edge rule so a same-cycle edge on
   // the granted requester sees the post-step pending value.
   always_comb begin
      w_edge = req_in & ~r_req_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_pend_next[i] = r_pend[i];
         w_sdir_next[i] = r_sdir[i];
         w_ovf_set[i]   = 1'b0;
         if (r_state == S_STEP && r_grant_id == c_id_w'(i) && r_pend[i] != '0)
            w_pend_next[i] = r_pend[i] - PEND_W'(1);
         if (w_edge[i]) begin
            if (w_pend_next[i] == '0) begin
               w_pend_next[i] = PEND_W'(1);
               w_sdir_next[i] = dir_in[i];
            end else if (dir_in[i] == r_sdir[i]) begin
               if (w_pend_next[i] == c_pend_max)
                  w_ovf_set[i] = 1'b1;
               else
                  w_pend_next[i] = w_pend_next[i] + PEND_W'(1);
            end else begin
               w_pend_next[i] = w_pend_next[i] - PEND_W'(1);
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_pend_nz[i] = (r_pend[i] != '0);
         w_next_nz[i] = (w_pend_next[i] != '0);
      end
   end

   assign w_rr_after  = (r_grant_id == c_id_w'(NUM_REQ - 1)) ? '0 : r_grant_id + c_id_w'(1);
   assign w_pick_now  = pick(w_pend_nz, r_rr_ptr);
   assign w_pick_step = pick(w_next_nz, w_rr_after);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_req_q    <= '0;
         r_sdir     <= '0;
         r_ovf      <= '0;
         r_rr_ptr   <= '0;
         r_grant_id <= '0;
         r_step_dir <= 1'b0;
         r_pulse    <= 1'b0;
         r_count    <= '0;
         r_gap      <= '0;
         for (int i = 0; i < NUM_REQ; i++) r_pend[i] <= '0;
      end else begin
         r_req_q <= req_in;
         r_pend  <= w_pend_next;
         r_sdir  <= w_sdir_next;
         r_ovf   <= r_ovf | w_ovf_set;
         r_pulse <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (enable && w_pick_now[c_id_w]) begin
                  r_state    <= S_GRANT;
                  r_grant_id <= w_pick_now[c_id_w-1:0];
                  r_step_dir <= r_sdir[w_pick_now[c_id_w-1:0]];
               end
            end
            S_GRANT: begin
               if (w_pend_next[r_grant_id] != '0) begin
                  r_state <= S_STEP;
                  r_pulse <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_STEP: begin
               r_count  <= r_step_dir ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
               r_rr_ptr <= w_rr_after;
               if (STEP_GAP == 0) begin
                  // No gap: arbitrate on post-step state to keep a 2-cycle cadence.
                  if (enable && w_pick_step[c_id_w]) begin
                     r_state    <= S_GRANT;
                     r_grant_id <= w_pick_step[c_id_w-1:0];
                     r_step_dir <= w_sdir_next[w_pick_step[c_id_w-1:0]];
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_state <= S_GAP;
                  r_gap   <= c_gap_w'(STEP_GAP - 1);
               end
            end
            S_GAP: begin
               // Last gap cycle doubles as the idle arbitration cycle.
               if (r_gap == '0) begin
                  if (enable && w_pick_now[c_id_w]) begin
                     r_state    <= S_GRANT;
                     r_grant_id <= w_pick_now[c_id_w-1:0];
                     r_step_dir <= r_sdir[w_pick_now[c_id_w-1:0]];
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_gap <= r_gap - c_gap_w'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign count      = r_count;
   assign step_pulse = r_pulse;
   assign step_dir   = r_step_dir;
   assign grant_id   = r_grant_id;
   assign pend_ovf   = r_ovf;
   assign busy       = (r_state != S_IDLE) | (|w_pend_nz);

endmodule
`default_nettype wire

// File: tb/tb_step_request_arbiter.sv
`default_nettype none
// ============================================================================
// tb_step_request_arbiter : scoreboard bench for step_request_arbiter.
// Revision 1.0
// ============================================================================
module tb_step_request_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req_in;
   logic [3:0] dir_in;
   logic       enable;
   logic [2:0] count;
   logic       step_pulse;
   logic       step_dir;
   logic [1:0] grant_id;
   logic [3:0] pend_ovf;
   logic       busy;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [1:0] id;
      logic       dir;
      logic [2:0] cnt;
   } step_t;

   step_t      exp_q[$];
   logic [2:0] exp_count;

   always #5 clk = ~clk;

   step_request_arbiter #(
      .NUM_REQ (4),
      .WIDTH   (3),
      .PEND_W  (2),
      .STEP_GAP(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_in    (req_in),
      .dir_in    (dir_in),
      .enable    (enable),
      .count     (count),
      .step_pulse(step_pulse),
      .step_dir  (step_dir),
      .grant_id  (grant_id),
      .pend_ovf  (pend_ovf),
      .busy      (busy)
   );

   // Every step_pulse pops the next expected step; count is checked one cycle later.
   initial begin : monitor
      step_t      e;
      logic       chk;
      logic [2:0] want;
      chk  = 1'b0;
      want = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            chk = 1'b0;
         end else begin
            if (chk) begin
               total++;
               if (count !== want) begin
                  bad++;
                  $display("FAIL step_count actual=%0d required=%0d", count, want);
               end
               chk = 1'b0;
            end
            if (step_pulse === 1'b1) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_step actual grant_id=%0d dir=%0d required no step",
                           grant_id, step_dir);
               end else begin
                  e = exp_q.pop_front();
                  if (grant_id !== e.id || step_dir !== e.dir) begin
                     bad++;
                     $display("FAIL step_grant actual id=%0d dir=%0d required id=%0d dir=%0d",
                              grant_id, step_dir, e.id, e.dir);
                  end
                  want = e.cnt;
                  chk  = 1'b1;
               end
            end
         end
      end
   end

   task automatic expect_step(input int id, input logic dir);
      exp_count = dir ? exp_count + 3'd1 : exp_count - 3'd1;
      exp_q.push_back(step_t'({2'(id), dir, exp_count}));
   endtask

   task automatic pulse_req(input logic [3:0] mask, input logic [3:0] dirs);
      @(negedge clk);
      dir_in = dirs;
      req_in = mask;
      @(negedge clk);
      req_in = '0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      reset  = 1'b1;
      req_in = '0;
      dir_in = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_count = '0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      req_in = '0;
      dir_in = '0;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (count      !== 3'd0)  begin bad++; $display("FAIL rst_count actual=%0d required=0", count); end
      total++; if (step_pulse !== 1'b0)  begin bad++; $display("FAIL rst_pulse actual=%0d required=0", step_pulse); end
      total++; if (step_dir   !== 1'b0)  begin bad++; $display("FAIL rst_dir actual=%0d required=0", step_dir); end
      total++; if (grant_id   !== 2'd0)  begin bad++; $display("FAIL rst_grant actual=%0d required=0", grant_id); end
      total++; if (pend_ovf   !== 4'h0)  begin bad++; $display("FAIL rst_ovf actual=%b required=0000", pend_ovf); end
      total++; if (busy       !== 1'b0)  begin bad++; $display("FAIL rst_busy actual=%0d required=0", busy); end
      reset     = 1'b0;
      enable    = 1'b1;
      exp_count = '0;
   endtask

   task automatic test_single();
      logic [2:0] sp;
      bit         ok;
      expect_step(0, 1'b1);
      @(negedge clk);
      dir_in = 4'b0001;
      req_in = 4'b0001;
      @(negedge clk);
      req_in = '0;
      sp[0]  = step_pulse;
      @(negedge clk);
      sp[1]  = step_pulse;
      @(negedge clk);
      sp[2]  = step_pulse;
      total++; if (sp !== 3'b100) begin bad++; $display("FAIL single_latency actual=%b required=100", sp); end
      wait_idle(20, ok);
      total++; if (!ok) begin bad++; $display("FAIL single_idle actual=busy required=idle"); end
      total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count actual=%0d required=1", count); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL single_grant actual=%0d required=0", grant_id); end
   endtask

   task automatic test_wrap();
      bit ok;
      for (int n = 0; n < 8; n++) begin
         expect_step(1, 1'b1);
         pulse_req(4'b0010, 4'b0010);
         repeat (8) @(negedge clk);
      end
      for (int n = 0; n < 2; n++) begin
         expect_step(1, 1'b0);
         pulse_req(4'b0010, 4'b0000);
         repeat (8) @(negedge clk);
      end
      wait_idle(20, ok);
      total++; if (!ok) begin bad++; $display("FAIL wrap_idle actual=busy required=idle"); end
      total++; if (count !== 3'd7) begin bad++; $display("FAIL wrap_count actual=%0d required=7", count); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_missing actual=%0d left required=0", exp_q.size()); end
   endtask

   task automatic test_simultaneous();
      int  t[3];
      int  n;
      bit  ok;
      apply_reset();
      expect_step(0, 1'b1);
      expect_step(2, 1'b1);
      expect_step(3, 1'b1);
      pulse_req(4'b1101, 4'b1101);
      n = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (step_pulse === 1'b1 && n < 3) begin
            t[n] = c;
            n++;
         end
      end
      total++; if (n != 3) begin bad++; $display("FAIL simul_steps actual=%0d required=3", n); end
      if (n == 3) begin
         total++; if (t[1] - t[0] != 4) begin bad++; $display("FAIL simul_gap01 actual=%0d required=4", t[1] - t[0]); end
         total++; if (t[2] - t[1] != 4) begin bad++; $display("FAIL simul_gap12 actual=%0d required=4", t[2] - t[1]); end
      end
      wait_idle(20, ok);
      total++; if (count !== 3'd3) begin bad++; $display("FAIL simul_count actual=%0d required=3", count); end
   endtask

   task automatic test_enable_saturate();
      bit ok;
      enable = 1'b0;
      for (int n = 0; n < 4; n++) begin
         pulse_req(4'b0100, 4'b0100);
         @(negedge clk);
      end
      repeat (6) @(negedge clk);
      total++; if (count !== exp_count) begin bad++; $display("FAIL hold_count actual=%0d required=%0d", count, exp_count); end
      total++; if (pend_ovf !== 4'b0100) begin bad++; $display("FAIL hold_ovf actual=%b required=0100", pend_ovf); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy actual=%0d required=1", busy); end
      for (int n = 0; n < 3; n++) expect_step(2, 1'b1);
      enable = 1'b1;
      wait_idle(40, ok);
      total++; if (!ok) begin bad++; $display("FAIL drain_idle actual=busy required=idle"); end
      total++; if (count !== exp_count) begin bad++; $display("FAIL drain_count actual=%0d required=%0d", count, exp_count); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL drain_missing actual=%0d left required=0", exp_q.size()); end
   endtask

   task automatic test_cancel();
      bit ok;
      @(negedge clk);
      dir_in = 4'b0010;
      req_in = 4'b0010;
      @(negedge clk);
      req_in = '0;
      @(negedge clk);
      dir_in = 4'b0000;
      req_in = 4'b0010;
      @(negedge clk);
      req_in = '0;
      wait_idle(20, ok);
      repeat (6) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy actual=%0d required=0", busy); end
      total++; if (count !== exp_count) begin bad++; $display("FAIL cancel_count actual=%0d required=%0d", count, exp_count); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      enable = 1'b0;
      for (int n = 0; n < 3; n++) begin
         pulse_req(4'b1000, 4'b1000);
         @(negedge clk);
      end
      expect_step(3, 1'b1);
      enable = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (step_pulse === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      total++; if (!ok) begin bad++; $display("FAIL mid_step_seen actual=none required=step"); end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL mid_count actual=%0d required=0", count); end
      total++; if (step_dir !== 1'b0 || grant_id !== 2'd0) begin bad++; $display("FAIL mid_grant actual id=%0d dir=%0d required 0/0", grant_id, step_dir); end
      total++; if (pend_ovf !== 4'h0) begin bad++; $display("FAIL mid_ovf actual=%b required=0000", pend_ovf); end
      total++; if (busy !== 1'b0 || step_pulse !== 1'b0) begin bad++; $display("FAIL mid_busy actual busy=%0d pulse=%0d required 0/0", busy, step_pulse); end
      @(negedge clk);
      reset = 1'b0;
      exp_count = '0;
      exp_q.delete();
      repeat (20) @(negedge clk);
      total++; if (count !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL mid_after actual count=%0d busy=%0d required 0/0", count, busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_simultaneous();
      test_enable_saturate();
      test_cancel();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
